// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with RV32M multiply/divide.
// Single-cycle ops finish with latency 1; multiply and divide iterate one
// bit per cycle on operand magnitudes and apply the sign on the last step.
// Optional build macro: ALU_SEQ_FAST_MUL_EN selects a single-cycle
// combinational multiplier for MUL/MULH/MULHSU/MULHU.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] left_operand,
  input  logic [DATA_WIDTH-1:0] right_operand,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag,
  output logic                  busy
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(17);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(18);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state, state_next, route;
  logic   accept;

  // Op decode for the operands currently on the inputs.
  logic          is_mul, is_div, is_rem;
  logic          a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic          div_by_zero, div_ovf, div_special;
  logic [SHW-1:0] shamt;
  logic [W-1:0]  quick;

  // Iterative datapath: {acc, lo} is the product / remainder:quotient pair.
  logic [W-1:0]  acc, lo, opnd;
  logic [CW-1:0] cnt;
  logic          neg, sel_alt;
  logic [W-1:0]  result_q;
  logic          zero_q;

  logic [W:0]    mul_sum, div_shift;
  logic          div_ge;
  logic [W-1:0]  div_diff, acc_step, lo_step;
  logic [2*W-1:0] prod_full, prod_fix;
  logic [W-1:0]  div_val, div_fix, iter_result;

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [W:0]       fa_ext, fb_ext;
  logic [2*W+1:0]   fast_prod;
`endif

  // Decode op class, operand signedness/magnitudes and divide special cases.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    is_mul      = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    is_div      = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    is_rem      = (op == OP_REM) || (op == OP_REMU);
    a_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg       = a_signed && left_operand[W-1];
    b_neg       = b_signed && right_operand[W-1];
    a_mag       = a_neg ? (~left_operand + 1'b1) : left_operand;
    b_mag       = b_neg ? (~right_operand + 1'b1) : right_operand;
    div_by_zero = (right_operand == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                  (left_operand == MOST_NEG) && (right_operand == '1);
    div_special = is_div && (div_by_zero || div_ovf);
    route       = ST_DONE;
    if (is_div && !div_special) begin
      route = ST_DIV;
    end
`ifndef ALU_SEQ_FAST_MUL_EN
    if (is_mul) begin
      route = ST_MUL;
    end
`endif
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  // Single-cycle signed (W+1)x(W+1) multiply covering all four signedness mixes.
  always_comb begin
    fa_ext    = {a_signed && left_operand[W-1], left_operand};
    fb_ext    = {b_signed && right_operand[W-1], right_operand};
    fast_prod = $signed({{(W+1){fa_ext[W]}}, fa_ext}) * $signed({{(W+1){fb_ext[W]}}, fb_ext});
  end
`endif

  // Latency-1 results: plain ALU ops, divide special cases, fast multiply.
  always_comb begin
    shamt = right_operand[SHW-1:0];
    quick = left_operand + right_operand;
    case (op)
      OP_ADD:  quick = left_operand + right_operand;
      OP_SUB:  quick = left_operand - right_operand;
      OP_SLL:  quick = left_operand << shamt;
      OP_SLT:  quick = {{(W-1){1'b0}}, $signed(left_operand) < $signed(right_operand)};
      OP_SLTU: quick = {{(W-1){1'b0}}, left_operand < right_operand};
      OP_XOR:  quick = left_operand ^ right_operand;
      OP_SRL:  quick = left_operand >> shamt;
      OP_SRA:  quick = $unsigned($signed(left_operand) >>> shamt);
      OP_OR:   quick = left_operand | right_operand;
      OP_AND:  quick = left_operand & right_operand;
      OP_LUI:  quick = right_operand;
      OP_DIV, OP_DIVU: quick = div_by_zero ? '1 : left_operand;
      OP_REM, OP_REMU: quick = div_by_zero ? left_operand : '0;
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL:  quick = fast_prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: quick = fast_prod[2*W-1:W];
`endif
      default: quick = left_operand + right_operand;
    endcase
  end

  // One shift-add or restoring-divide step, plus sign fixup of the stepped value.
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_shift = {acc, lo[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[W-1:0] - opnd;
    if (state == ST_MUL) begin
      acc_step = mul_sum[W:1];
      lo_step  = {mul_sum[0], lo[W-1:1]};
    end else begin
      acc_step = div_ge ? div_diff : div_shift[W-1:0];
      lo_step  = {lo[W-2:0], div_ge};
    end
    prod_full = {acc_step, lo_step};
    prod_fix  = neg ? (~prod_full + 1'b1) : prod_full;
    div_val   = sel_alt ? acc_step : lo_step;
    div_fix   = neg ? (~div_val + 1'b1) : div_val;
    if (state == ST_MUL) begin
      iter_result = sel_alt ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
    end else begin
      iter_result = div_fix;
    end
  end

  // Handshake and next-state selection; flush overrides everything but reset.
  always_comb begin
    in_ready   = !reset && !flush &&
                 ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    accept     = in_valid && in_ready;
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = route;
      ST_MUL:  if (cnt == CNT_LAST) state_next = ST_DONE;
      ST_DIV:  if (cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE: begin
        if (accept) begin
          state_next = route;
        end else if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: operand capture on accept, one iteration per MUL/DIV cycle.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, so a reset mid-operation
    // leaves no partial product or remainder behind and result reads 0.
    if (reset) begin
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      sel_alt  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (route == ST_MUL) begin
        acc     <= '0;
        lo      <= b_mag;
        opnd    <= a_mag;
        neg     <= a_neg ^ b_neg;
        sel_alt <= (op != OP_MUL);
      end else if (route == ST_DIV) begin
        acc     <= '0;
        lo      <= a_mag;
        opnd    <= b_mag;
        neg     <= is_rem ? a_neg : (a_neg ^ b_neg);
        sel_alt <= is_rem;
      end else begin
        result_q <= quick;
        zero_q   <= (quick == '0);
      end
    end else if ((state == ST_MUL) || (state == ST_DIV)) begin
      acc <= acc_step;
      lo  <= lo_step;
      cnt <= cnt + CW'(1);
      if (cnt == CNT_LAST) begin
        result_q <= iter_result;
        zero_q   <= (iter_result == '0);
      end
    end
  end

  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_DIV);
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (DATA_WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLT = 5'd3, SLTU = 5'd4,
                         SRA = 5'd7, LUI = 5'd10, MUL = 5'd11, MULH = 5'd12,
                         MULHSU = 5'd13, MULHU = 5'd14, DIV = 5'd15, DIVU = 5'd16,
                         REM = 5'd17, REMU = 5'd18;

`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, zero_flag, busy;
  logic [4:0]  op;
  logic [31:0] left_operand, right_operand, result;
  int          n_vec = 0;
  int          n_err = 0;
  logic        seen;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .left_operand(left_operand), .right_operand(right_operand),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op, then scramble the operand inputs after acceptance.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input int exp_busy,
                        input logic [31:0] exp_res);
    int lat = 0;
    int bc  = 0;
    op = o; left_operand = a; right_operand = b; in_valid = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; op = 5'd9; left_operand = 32'hDEAD_BEEF; right_operand = 32'h1234_5678;
      end
      if (busy) bc++;
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero_flag"}, {31'd0, zero_flag}, {31'd0, exp_res == 32'd0});
  endtask

  initial begin
    // Reset held two cycles with an op offered.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    op = ADD; left_operand = 32'd1; right_operand = 32'd1;
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1 check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // Single-cycle ops.
    run_op("ADD overflow", ADD, 32'h7FFF_FFFF, 32'd1, 1, 0, 32'h8000_0000);
    run_op("SUB 5-5", SUB, 32'd5, 32'd5, 1, 0, 32'd0);
    run_op("SRA by 35", SRA, 32'h8000_0000, 32'd35, 1, 0, 32'hF000_0000);
    run_op("SLT -1<1", SLT, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'd1);
    run_op("SLTU max<1", SLTU, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'd0);
    run_op("LUI", LUI, 32'h1111_1111, 32'hABCD_E000, 1, 0, 32'hABCD_E000);
    run_op("unknown op as ADD", 5'd31, 32'd3, 32'd4, 1, 0, 32'd7);

    // Multiply.
    run_op("MULH -1*-1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, 32'd0);
    run_op("MULHU max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, 32'hFFFF_FFFE);
    run_op("MUL 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, MUL_LAT, MUL_BUSY, 32'hFFFF_FFEB);
    run_op("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, 32'hFFFF_FFFF);

    // Divide: special cases at latency 1, iterative at latency 33.
    run_op("DIV overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000);
    run_op("REM overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'd0);
    run_op("DIVU by zero", DIVU, 32'd100, 32'd0, 1, 0, 32'hFFFF_FFFF);
    run_op("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFF);
    run_op("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32, 32'hFFFF_FFFD);
    run_op("REMU by zero", REMU, 32'd7, 32'd0, 1, 0, 32'd7);

    // Backpressure: result held while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 33, 32, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held out_valid", {31'd0, out_valid}, 32'd1);
      check("held result", result, 32'd14);
      check("held in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = ADD; left_operand = 32'd1; right_operand = 32'd2;
    #1 check("consume+accept in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("back-to-back out_valid", {31'd0, out_valid}, 32'd1);
    check("back-to-back ADD result", result, 32'd3);

    // Flush at cycle 10 of a divide, with an op offered alongside.
    @(negedge clk);
    in_valid = 1'b1; op = DIV; left_operand = 32'd100; right_operand = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy before flush", {31'd0, busy}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; op = ADD; left_operand = 32'd9; right_operand = 32'd9;
    #1 check("in_ready during flush", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("out_valid after flush", {31'd0, out_valid}, 32'd0);
    check("busy after flush", {31'd0, busy}, 32'd0);
    #1 check("in_ready after flush", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flushed op never valid", {31'd0, seen}, 32'd0);
    run_op("ADD 2+2 after flush", ADD, 32'd2, 32'd2, 1, 0, 32'd4);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; op = DIVU; left_operand = 32'd1000; right_operand = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-op reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-op reset busy", {31'd0, busy}, 32'd0);
    check("mid-op reset result", result, 32'd0);
    run_op("ADD after mid-op reset", ADD, 32'd10, 32'd20, 1, 0, 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
